lcd_hd44780_ctrl: RTL and testbench

Hardware write engine for the HD44780-compatible character LCD behind the LSU's LCD I/O register. The core or LSU glue presents {RS, data} commands over a valid/ready handshake. The block generates the LCD pin timing (setup, EN pulse, hold, execution wait) and runs an optional power-on init sequence. It drives the LCD pins directly and exposes busy/done/count status so software can poll it through the I/O read path.

---
 rtl/lcd_hd44780_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD write engine: pin timing, power-on init,
// and busy/done/count status for software polling.
module lcd_hd44780_ctrl #(
  parameter int SETUP_CYC      = 3,
  parameter int EN_HIGH_CYC    = 12,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int POWERON_CYC    = 750000,
  parameter bit INIT_EN        = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  input  logic        i_cmd_rs,
  input  logic [7:0]  i_cmd_data,
  input  logic        i_lcd_on,
  output logic        o_cmd_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_cmd_count,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = imax(
    imax(imax(SETUP_CYC, EN_HIGH_CYC), imax(HOLD_CYC, CMD_WAIT_CYC)),
    imax(CLEAR_WAIT_CYC, POWERON_CYC));
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] L_EN    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] L_CLEAR = CW'(CLEAR_WAIT_CYC - 1);
  localparam logic [CW-1:0] L_PON   = CW'(POWERON_CYC - 1);

  typedef enum logic [2:0] {
    ST_PWR,
    ST_SETUP,
    ST_EN,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } state_t;

  localparam state_t RST_ST = INIT_EN ? ST_PWR : ST_IDLE;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_idx;
  logic           r_host;
  logic           r_ready;
  logic [15:0]    r_cmd_count;

  logic           w_zero;
  logic           w_accept;
  logic           w_clear;
  logic [CW-1:0]  w_exec_ld;

  assign w_zero    = (r_cnt == '0);
  assign w_accept  = i_cmd_valid & r_ready & (r_state == ST_IDLE);
  // clear (0x01) and return-home (0x02/0x03) need the long wait
  assign w_clear   = ~o_lcd_rs & (o_lcd_data[7:2] == 6'd0)
                   & (o_lcd_data[1:0] != 2'd0);
  assign w_exec_ld = w_clear ? L_CLEAR : L_CMD;

  assign o_cmd_ready = r_ready;
  assign o_busy      = ~r_ready;
  assign o_cmd_count = r_cmd_count;
  assign o_lcd_rw    = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= RST_ST;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_host      <= 1'b0;
      r_ready     <= 1'b0;
      r_cmd_count <= 16'd0;
      o_done      <= 1'b0;
      o_lcd_data  <= 8'd0;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_on    <= 1'b0;
    end else begin
      o_lcd_on <= i_lcd_on;
      o_done   <= 1'b0;
      case (r_state)
        ST_PWR: begin
          if (r_cnt == L_PON) begin
            r_state    <= ST_SETUP;
            r_cnt      <= L_SETUP;
            r_host     <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= init_byte(2'd0);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_SETUP: begin
          if (w_zero) begin
            r_state  <= ST_EN;
            r_cnt    <= L_EN;
            o_lcd_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_EN: begin
          if (w_zero) begin
            r_state  <= ST_HOLD;
            r_cnt    <= L_HOLD;
            o_lcd_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_zero) begin
            r_state <= ST_EXEC;
            r_cnt   <= w_exec_ld;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_EXEC: begin
          if (!w_zero) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (r_host) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            o_done      <= 1'b1;
            r_cmd_count <= r_cmd_count + 16'd1;
          end else if (r_idx == 2'd3) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_state    <= ST_SETUP;
            r_cnt      <= L_SETUP;
            r_idx      <= r_idx + 2'd1;
            o_lcd_data <= init_byte(r_idx + 2'd1);
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_SETUP;
            r_cnt      <= L_SETUP;
            r_host     <= 1'b1;
            r_ready    <= 1'b0;
            o_lcd_rs   <= i_cmd_rs;
            o_lcd_data <= i_cmd_data;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected EN pulses and
// completions are queued at issue time and popped by a monitor.
module tb_lcd_hd44780_ctrl;

  localparam int S    = 2;
  localparam int E    = 4;
  localparam int H    = 1;
  localparam int WCMD = 10;
  localparam int WCLR = 50;
  localparam int PON  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset;
  logic        i_cmd_valid;
  logic        i_cmd_rs;
  logic [7:0]  i_cmd_data;
  logic        i_lcd_on;
  logic        o_cmd_ready;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_cmd_count;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;

  lcd_hd44780_ctrl #(
    .SETUP_CYC(S), .EN_HIGH_CYC(E), .HOLD_CYC(H),
    .CMD_WAIT_CYC(WCMD), .CLEAR_WAIT_CYC(WCLR),
    .POWERON_CYC(PON), .INIT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .i_cmd_rs(i_cmd_rs),
    .i_cmd_data(i_cmd_data), .i_lcd_on(i_lcd_on),
    .o_cmd_ready(o_cmd_ready), .o_busy(o_busy),
    .o_done(o_done), .o_cmd_count(o_cmd_count),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en),
    .o_lcd_on(o_lcd_on)
  );

  typedef struct {int c; logic rs; logic [7:0] d;} en_t;
  typedef struct {int c; logic [15:0] n;} dn_t;

  en_t         en_q[$];
  dn_t         dn_q[$];
  en_t         e_pop;
  dn_t         d_pop;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_until = 0;
  logic [15:0] exp_cnt = 16'd0;
  bit          mon_en = 1'b0;
  logic        exp_on = 1'b0;
  logic        prev_en = 1'b0;
  int          en_len = 0;
  logic        en_rs = 1'b0;
  logic [7:0]  en_d = 8'd0;
  logic [7:0]  ib [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) exp_on <= i_reset ? 1'b0 : i_lcd_on;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // execution wait chosen by the command itself
  function automatic int wcyc(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? WCLR : WCMD;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready", 32'(o_cmd_ready), 32'(cyc >= busy_until));
      chk("busy", 32'(o_busy), 32'(cyc < busy_until));
      chk("lcd_on", 32'(o_lcd_on), 32'(exp_on));
      chk("rw", 32'(o_lcd_rw), 32'd0);
      if (o_lcd_en && !prev_en) begin
        if (en_q.size() == 0) begin
          fail("en_unexpected");
        end else begin
          e_pop = en_q.pop_front();
          chk("en_cycle", cyc, e_pop.c);
          chk("en_rs", 32'(o_lcd_rs), 32'(e_pop.rs));
          chk("en_data", 32'(o_lcd_data), 32'(e_pop.d));
        end
        en_len = 1;
        en_rs  = o_lcd_rs;
        en_d   = o_lcd_data;
      end else if (o_lcd_en) begin
        en_len++;
        chk("bus_stable", 32'({o_lcd_rs, o_lcd_data}),
            32'({en_rs, en_d}));
      end else if (prev_en) begin
        chk("en_width", en_len, E);
        chk("hold_bus", 32'({o_lcd_rs, o_lcd_data}),
            32'({en_rs, en_d}));
      end
      if (en_q.size() > 0 && en_q[0].c <= cyc) begin
        void'(en_q.pop_front());
        fail("en_missing");
      end
      if (o_done) begin
        if (dn_q.size() == 0) begin
          fail("done_unexpected");
        end else begin
          d_pop = dn_q.pop_front();
          chk("done_cycle", cyc, d_pop.c);
          chk("count", 32'(o_cmd_count), 32'(d_pop.n));
        end
      end
      if (dn_q.size() > 0 && dn_q[0].c <= cyc) begin
        void'(dn_q.pop_front());
        fail("done_missing");
      end
      prev_en = o_lcd_en;
    end
  end

  task automatic do_reset(input int n);
    int t;
    mon_en      = 1'b0;
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    @(posedge clk) #1;
    chk("rst_en", 32'(o_lcd_en), 32'd0);
    chk("rst_ready", 32'(o_cmd_ready), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_count", 32'(o_cmd_count), 32'd0);
    chk("rst_bus", 32'({o_lcd_rs, o_lcd_data}), 32'd0);
    chk("rst_on", 32'(o_lcd_on), 32'd0);
    repeat (n - 1) @(posedge clk) #1;
    i_reset = 1'b0;
    en_q.delete();
    dn_q.delete();
    prev_en = 1'b0;
    exp_cnt = 16'd0;
    t = cyc + PON;
    for (int i = 0; i < 4; i++) begin
      en_q.push_back('{t + S, 1'b0, ib[i]});
      t += S + E + H + wcyc(1'b0, ib[i]);
    end
    busy_until = t;
    mon_en = 1'b1;
  endtask

  task automatic send(input logic rs, input logic [7:0] d,
                      input bit keep, input bit junk, output int a);
    int n;
    int w;
    n = 0;
    a = -1;
    i_cmd_valid = 1'b1;
    i_cmd_rs    = rs;
    i_cmd_data  = d;
    while (!o_cmd_ready) begin
      if (junk) begin
        i_cmd_rs   = 1'($urandom);
        i_cmd_data = 8'($urandom);
      end
      @(posedge clk) #1;
      n++;
      if (n > 500) begin
        fail("send_timeout");
        i_cmd_valid = 1'b0;
        return;
      end
    end
    i_cmd_rs   = rs;
    i_cmd_data = d;
    a = cyc;
    @(posedge clk) #1;
    w = wcyc(rs, d);
    exp_cnt = exp_cnt + 16'd1;
    en_q.push_back('{a + S + 1, rs, d});
    dn_q.push_back('{a + S + E + H + w + 1, exp_cnt});
    busy_until = a + S + E + H + w + 1;
    if (!keep) i_cmd_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk) #1;
      i_lcd_on = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    int a2;
    int n;
    logic rs;
    logic [7:0] d;
    bit keep;
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_rs    = 1'b0;
    i_cmd_data  = 8'd0;
    i_lcd_on    = 1'b0;

    do_reset(3);
    send(1'b1, 8'h41, 1'b0, 1'b0, a1);
    send(1'b0, 8'h01, 1'b0, 1'b0, a1);
    send(1'b0, 8'h80, 1'b0, 1'b1, a1);
    send(1'b1, 8'h41, 1'b1, 1'b0, a1);
    send(1'b1, 8'h42, 1'b0, 1'b1, a2);
    chk("b2b_gap", a2 - a1, S + E + H + WCMD + 1);

    send(1'b1, 8'h55, 1'b0, 1'b0, a1);
    while (cyc < a1 + S + 2) @(posedge clk) #1;
    do_reset(1);

    send(1'b0, 8'h0F, 1'b0, 1'b0, a1);
    while (cyc < busy_until + 2) @(posedge clk) #1;
    force dut.r_cmd_count = 16'hFFFF;
    @(posedge clk) #1;
    release dut.r_cmd_count;
    @(posedge clk) #1;
    chk("count_preload", 32'(o_cmd_count), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    send(1'b1, 8'h5A, 1'b0, 1'b0, a1);

    for (int i = 0; i < 40; i++) begin
      rs   = 1'($urandom);
      d    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                         : 8'($urandom);
      keep = ($urandom_range(0, 2) == 0);
      send(rs, d, keep, 1'($urandom), a1);
      if (!keep) repeat ($urandom_range(0, 5)) @(posedge clk) #1;
    end
    i_cmd_valid = 1'b0;

    n = 0;
    while ((en_q.size() > 0 || dn_q.size() > 0) && n < 1000) begin
      @(posedge clk) #1;
      n++;
    end
    if (en_q.size() > 0 || dn_q.size() > 0) fail("drain_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
